drawing_datapath: RTL and testbench
===================================

Name: drawing_datapath

Overview:
Datapath partner of the drawing control FSM. It takes the FSM's 3-bit state code and the latest mouse cursor position, and turns each active state into a raster sweep of pixel writes to the VGA adapter. It pulses a one-cycle done back to the FSM as that FSM's iDone input when each sweep completes. It also keeps the current and previous cursor positions, so CLEAN can erase the old cursor fragment.

Parameters:
WIDTH, 160, screen width in pixels
HEIGHT, 120, screen height in pixels
XW, 8, x coordinate width
YW, 7, y coordinate width
CURSOR_SIZE, 4, cursor box edge length in pixels (MOVE and CLEAN)
BRUSH_SIZE, 2, brush box edge length in pixels (DRAW and ERASE)
CURSOR_COLOUR, 3'b111, colour used to paint the cursor
BG_COLOUR, 3'b000, background colour for ERASE, CLEAN and CLEAR

Ports:
iClk  in  1  system clock; all logic on rising edge
iReset  in  1  synchronous, active-high reset
iState  in  3  FSM state: 0 IDLE, 1 MOVE, 2 WAIT, 3 CLEAN, 4 DRAW, 5 ERASE, 6 CLEAR
iX  in  XW  mouse cursor x
iY  in  YW  mouse cursor y
iColour  in  3  user-selected draw colour
oX  out  XW  pixel x to VGA adapter
oY  out  YW  pixel y to VGA adapter
oColour  out  3  pixel colour
oPlot  out  1  write enable for the VGA adapter
oDone  out  1  one-cycle sweep-complete pulse to the FSM

Behaviour:
- Reset (iReset=1 at an edge):
  - oX, oY, oColour, oPlot and oDone all go to 0.
  - The sweep counters clear and busy clears.
  - curPos and prevPos go to (0,0).
  - lastState goes to IDLE.
  - Reset overrides everything, including an in-progress sweep.
- All outputs are registered.
- Entry detection:
  - At an edge where iState differs from lastState, the block performs an entry.
  - On entry, lastState loads iState and the counters cx, cy clear to 0.
  - busy sets if iState is MOVE, CLEAN, DRAW, ERASE or CLEAR; otherwise busy clears.
  - oPlot and oDone are 0 on the entry edge.
- Latches taken at the entry edge:
  - MOVE: prevPos<=curPos and curPos<=(iX,iY).
  - DRAW and ERASE: base<=(iX,iY).
  - CLEAN: base<=prevPos.
  - CLEAR: base<=(0,0).
- Sweep extent: S×S box from base.
  - S = CURSOR_SIZE for MOVE and CLEAN; BRUSH_SIZE for DRAW and ERASE.
  - CLEAR covers WIDTH×HEIGHT.
- Sweep timing:
  - Order is raster, x fastest: cx increments; on cx==S-1 it wraps to 0 and cy increments.
  - For an N-pixel sweep, edges E+1..E+N register pixel k as oX=base.x+cx, oY=base.y+cy.
  - At edge E+N+1: oDone=1 and oPlot=0, busy clears.
  - At edge E+N+2: oDone=0.
  - oDone is high for exactly one cycle per entry.
- Colour per state:
  - MOVE: CURSOR_COLOUR.
  - DRAW: iColour, sampled per pixel.
  - ERASE, CLEAN, CLEAR: BG_COLOUR.
- oPlot=1 for a swept pixel unless it is masked by either rule below. A masked pixel still consumes its cycle, so N is unchanged.
  - Clipping: base+offset ≥ WIDTH or ≥ HEIGHT. Compare at XW+1 / YW+1 bits; no wrap-around onto the opposite edge.
  - CLEAN only: the pixel lies inside the current cursor box (curPos, CURSOR_SIZE). This prevents erasing the freshly drawn cursor.
- States IDLE, WAIT and 7: no sweep, oPlot=0, oDone=0.
- After done with iState unchanged: no restart, no further oDone until iState changes.
- iState changes mid-sweep: the current sweep aborts with no oDone. The new state performs a fresh entry at that edge.
- Non-plotting cycles hold oX and oY at their last value and drive oPlot=0.

Test Plan:
- Basic DRAW, single-pulse oDone:
  - Stimulus: reset; iState=DRAW, iX=10, iY=20, iColour=3'b100, entry edge E.
  - Required: oPlot=1 with colour 4 at (10,20),(11,20),(10,21),(11,21) on E+1..E+4.
  - Required: oDone=1 at E+5 only; no further oDone while iState stays DRAW.
- MOVE then CLEAN:
  - Stimulus: MOVE to (50,40); MOVE to (52,40); then CLEAN.
  - Required: CLEAN runs 16 cycles with oPlot=1 only for x∈{50,51} (8 plots, colour 0); oDone at E+17.
- Edge clipping: DRAW at (159,119) -> only (159,119) plotted; oDone at E+5; no plot at x=0 or y=0.
- Full CLEAR:
  - Stimulus: iState=CLEAR.
  - Required: 19200 plots of colour 0, first (0,0), last (159,119) at E+19200; oDone at E+19201.
- Reset mid-CLEAR:
  - Stimulus: iReset=1 for one edge at pixel 100.
  - Required: next cycle all outputs 0.
  - Required: after release with iState=CLEAR, a new entry occurs and the sweep restarts at (0,0).
- Abort on state change: change iState from DRAW to ERASE after 2 pixels -> no oDone for DRAW; a full 4-pixel ERASE sweep follows with oDone.

Source files
------------

// File: rtl/drawing_datapath.sv
// Raster-sweep pixel generator driven by the drawing FSM's state code.
// Turns each active state into a box/full-screen sweep of VGA writes and pulses oDone when finished.
//
// iState | meaning
// -------+---------------------------------------------------------------
// IDLE   | no sweep
// MOVE   | paint cursor box at new mouse position, shift cur -> prev
// WAIT   | no sweep
// CLEAN  | erase old cursor box at prevPos, skipping the current cursor box
// DRAW   | paint brush box at mouse position in user colour
// ERASE  | paint brush box at mouse position in background colour
// CLEAR  | paint whole screen in background colour
// 7      | reserved, no sweep
module drawing_datapath #(
    parameter int         WIDTH         = 160,
    parameter int         HEIGHT        = 120,
    parameter int         XW            = 8,
    parameter int         YW            = 7,
    parameter int         CURSOR_SIZE   = 4,
    parameter int         BRUSH_SIZE    = 2,
    parameter logic [2:0] CURSOR_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic [2:0]    iState,
    input  logic [XW-1:0] iX,
    input  logic [YW-1:0] iY,
    input  logic [2:0]    iColour,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic [2:0]    oColour,
    output logic          oPlot,
    output logic          oDone
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLEAN = 3'd3,
        ST_DRAW  = 3'd4,
        ST_ERASE = 3'd5,
        ST_CLEAR = 3'd6,
        ST_RSVD  = 3'd7
    } state_e;

    state_e        last_q, last_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [XW-1:0] base_x_q, base_x_d;
    logic [YW-1:0] base_y_q, base_y_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic [XW-1:0] prev_x_q, prev_x_d;
    logic [YW-1:0] prev_y_q, prev_y_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    col_q, col_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;

    state_e        st_in;
    logic [XW-1:0] sx_m1;
    logic [YW-1:0] sy_m1;
    logic [XW:0]   px;
    logic [YW:0]   py;
    logic          clip;
    logic          in_cur;
    logic          mask;
    logic          last_pix;
    logic [2:0]    pix_col;

    assign st_in = state_e'(iState);

    always_comb begin
        sx_m1   = XW'(WIDTH - 1);
        sy_m1   = YW'(HEIGHT - 1);
        pix_col = BG_COLOUR;
        case (last_q)
            ST_MOVE: begin
                sx_m1   = XW'(CURSOR_SIZE - 1);
                sy_m1   = YW'(CURSOR_SIZE - 1);
                pix_col = CURSOR_COLOUR;
            end
            ST_CLEAN: begin
                sx_m1 = XW'(CURSOR_SIZE - 1);
                sy_m1 = YW'(CURSOR_SIZE - 1);
            end
            ST_DRAW: begin
                sx_m1   = XW'(BRUSH_SIZE - 1);
                sy_m1   = YW'(BRUSH_SIZE - 1);
                pix_col = iColour;
            end
            ST_ERASE: begin
                sx_m1 = XW'(BRUSH_SIZE - 1);
                sy_m1 = YW'(BRUSH_SIZE - 1);
            end
            default: ;
        endcase
    end

    // One extra bit so boxes hanging off the right/bottom edge clip instead of wrapping.
    always_comb begin
        px       = {1'b0, base_x_q} + {1'b0, cx_q};
        py       = {1'b0, base_y_q} + {1'b0, cy_q};
        clip     = (px >= (XW+1)'(WIDTH)) || (py >= (YW+1)'(HEIGHT));
        in_cur   = (px >= {1'b0, cur_x_q}) && (px < {1'b0, cur_x_q} + (XW+1)'(CURSOR_SIZE)) &&
                   (py >= {1'b0, cur_y_q}) && (py < {1'b0, cur_y_q} + (YW+1)'(CURSOR_SIZE));
        mask     = clip || ((last_q == ST_CLEAN) && in_cur);
        last_pix = (cx_q == sx_m1) && (cy_q == sy_m1);
    end

    always_comb begin
        last_d   = last_q;
        busy_d   = busy_q;
        fin_d    = fin_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;

        if (st_in != last_q) begin
            last_d = st_in;
            cx_d   = '0;
            cy_d   = '0;
            fin_d  = 1'b0;
            busy_d = st_in inside {ST_MOVE, ST_CLEAN, ST_DRAW, ST_ERASE, ST_CLEAR};
            case (st_in)
                ST_MOVE: begin
                    prev_x_d = cur_x_q;
                    prev_y_d = cur_y_q;
                    cur_x_d  = iX;
                    cur_y_d  = iY;
                    base_x_d = iX;
                    base_y_d = iY;
                end
                ST_DRAW, ST_ERASE: begin
                    base_x_d = iX;
                    base_y_d = iY;
                end
                ST_CLEAN: begin
                    base_x_d = prev_x_q;
                    base_y_d = prev_y_q;
                end
                ST_CLEAR: begin
                    base_x_d = '0;
                    base_y_d = '0;
                end
                default: ;
            endcase
        end else if (busy_q) begin
            if (fin_q) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                fin_d  = 1'b0;
            end else begin
                // Masked pixels still take their cycle but leave oX/oY/oColour untouched.
                plot_d = !mask;
                if (!mask) begin
                    x_d   = px[XW-1:0];
                    y_d   = py[YW-1:0];
                    col_d = pix_col;
                end
                if (last_pix) begin
                    fin_d = 1'b1;
                end else if (cx_q == sx_m1) begin
                    cx_d = '0;
                    cy_d = cy_q + YW'(1);
                end else begin
                    cx_d = cx_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            last_q   <= ST_IDLE;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            last_q   <= last_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = col_q;
    assign oPlot   = plot_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_drawing_datapath.sv
// Bench for drawing_datapath: directed scenarios plus random state/position sequences,
// scored against a box-sweep model built from plain loops over the pixel list.
module tb_drawing_datapath;

    localparam int W = 160;
    localparam int H = 120;
    localparam int S_MOVE = 1, S_WAIT = 2, S_CLEAN = 3, S_DRAW = 4, S_ERASE = 5, S_CLEAR = 6;

    logic       clk = 1'b0;
    logic       iReset = 1'b1;
    logic [2:0] iState = 3'd0;
    logic [7:0] iX = '0;
    logic [6:0] iY = '0;
    logic [2:0] iColour = '0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot;
    logic       oDone;

    int checks = 0;
    int errors = 0;

    // model state
    int m_cur_x = 0, m_cur_y = 0, m_prev_x = 0, m_prev_y = 0;
    int cur_st = 0;
    int exp_plot[$], exp_x[$], exp_y[$], exp_c[$];
    // observations
    int obs_plot[$], obs_x[$], obs_y[$], obs_c[$], obs_done[$], drv_col[$];
    int entry_plot, entry_done;

    drawing_datapath dut (
        .iClk(clk), .iReset(iReset), .iState(iState), .iX(iX), .iY(iY), .iColour(iColour),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oDone(oDone)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cur_x = 0; m_cur_y = 0; m_prev_x = 0; m_prev_y = 0;
    endfunction

    // Expected pixel list for the sweep started by entering state st with mouse at (x,y).
    function automatic void model_enter(int st, int x, int y);
        int bx, by, sx, sy, px, py, p;
        cur_st = st;
        exp_plot.delete(); exp_x.delete(); exp_y.delete(); exp_c.delete();
        bx = 0; by = 0; sx = 0; sy = 0;
        case (st)
            S_MOVE: begin
                m_prev_x = m_cur_x; m_prev_y = m_cur_y;
                m_cur_x = x; m_cur_y = y;
                bx = x; by = y; sx = 4; sy = 4;
            end
            S_CLEAN: begin bx = m_prev_x; by = m_prev_y; sx = 4; sy = 4; end
            S_DRAW, S_ERASE: begin bx = x; by = y; sx = 2; sy = 2; end
            S_CLEAR: begin sx = W; sy = H; end
            default: ;
        endcase
        for (int j = 0; j < sy; j++) begin
            for (int i = 0; i < sx; i++) begin
                px = bx + i; py = by + j;
                p = (px < W && py < H) ? 1 : 0;
                if (st == S_CLEAN && px >= m_cur_x && px < m_cur_x + 4 && py >= m_cur_y && py < m_cur_y + 4)
                    p = 0;
                exp_plot.push_back(p);
                exp_x.push_back(px);
                exp_y.push_back(py);
                exp_c.push_back(st == S_MOVE ? 7 : 0);
            end
        end
    endfunction

    // Called at a negedge; drives the new state, samples the entry edge's outputs.
    task automatic enter(input int st, input int x, input int y);
        iState = 3'(st); iX = 8'(x); iY = 7'(y);
        model_enter(st, x, y);
        obs_plot.delete(); obs_x.delete(); obs_y.delete(); obs_c.delete(); obs_done.delete(); drv_col.delete();
        @(negedge clk);
        entry_plot = int'(oPlot);
        entry_done = int'(oDone);
    endtask

    task automatic capture(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = $urandom_range(0, 7);
            iColour = 3'(c);
            drv_col.push_back(c);
            @(negedge clk);
            obs_plot.push_back(int'(oPlot));
            obs_x.push_back(int'(oX));
            obs_y.push_back(int'(oY));
            obs_c.push_back(int'(oColour));
            obs_done.push_back(int'(oDone));
        end
    endtask

    task automatic test_sweep(input string name, input int st, input int x, input int y,
                              input int extra, output int nplots);
        int n, total, wc;
        enter(st, x, y);
        checks++;
        if (entry_plot !== 0 || entry_done !== 0) begin
            errors++;
            $display("FAIL %s entry: plot=%0d done=%0d, want 0 0", name, entry_plot, entry_done);
        end
        n = exp_plot.size();
        total = (n > 0) ? n + 1 + extra : extra;
        capture(total);
        nplots = 0;
        for (int k = 0; k < n; k++) begin
            wc = (st == S_DRAW) ? drv_col[k] : exp_c[k];
            if (obs_plot[k] == 1) nplots++;
            checks++;
            if (obs_plot[k] !== exp_plot[k] || obs_done[k] !== 0 ||
                (exp_plot[k] == 1 && (obs_x[k] !== exp_x[k] || obs_y[k] !== exp_y[k] || obs_c[k] !== wc))) begin
                errors++;
                $display("FAIL %s pixel %0d: got plot=%0d (%0d,%0d) c=%0d done=%0d, want plot=%0d (%0d,%0d) c=%0d done=0",
                         name, k, obs_plot[k], obs_x[k], obs_y[k], obs_c[k], obs_done[k],
                         exp_plot[k], exp_x[k], exp_y[k], wc);
            end
        end
        if (n > 0) begin
            checks++;
            if (obs_done[n] !== 1 || obs_plot[n] !== 0) begin
                errors++;
                $display("FAIL %s done at E+%0d: got done=%0d plot=%0d, want 1 0", name, n + 1, obs_done[n], obs_plot[n]);
            end
        end
        for (int k = (n > 0 ? n + 1 : 0); k < total; k++) begin
            checks++;
            if (obs_done[k] !== 0 || obs_plot[k] !== 0) begin
                errors++;
                $display("FAIL %s quiet cycle %0d: got done=%0d plot=%0d, want 0 0", name, k, obs_done[k], obs_plot[k]);
            end
        end
    endtask

    task automatic test_reset();
        iReset = 1'b1; iState = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (oX !== 0 || oY !== 0 || oColour !== 0 || oPlot !== 0 || oDone !== 0) begin
            errors++;
            $display("FAIL reset: got x=%0d y=%0d c=%0d plot=%0b done=%0b, want all 0", oX, oY, oColour, oPlot, oDone);
        end
        iReset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (oPlot !== 0 || oDone !== 0) begin
            errors++;
            $display("FAIL reset idle: got plot=%0b done=%0b, want 0 0", oPlot, oDone);
        end
    endtask

    task automatic test_draw_basic();
        int np;
        test_sweep("draw_basic", S_DRAW, 10, 20, 10, np);
        checks++;
        if (np !== 4) begin
            errors++;
            $display("FAIL draw_basic count: got %0d plots, want 4", np);
        end
    endtask

    task automatic test_move_clean();
        int np;
        test_sweep("move1", S_MOVE, 50, 40, 2, np);
        test_sweep("wait", S_WAIT, 0, 0, 3, np);
        test_sweep("move2", S_MOVE, 52, 40, 2, np);
        test_sweep("clean", S_CLEAN, 7, 9, 3, np);
        checks++;
        if (np !== 8) begin
            errors++;
            $display("FAIL clean count: got %0d plots, want 8", np);
        end
    endtask

    task automatic test_clip();
        int np;
        test_sweep("clip_idle", 0, 0, 0, 1, np);
        test_sweep("clip_draw", S_DRAW, 159, 119, 3, np);
        checks++;
        if (np !== 1) begin
            errors++;
            $display("FAIL clip count: got %0d plots, want 1", np);
        end
    endtask

    task automatic test_clear();
        int np;
        test_sweep("clear", S_CLEAR, 33, 44, 3, np);
        checks++;
        if (np !== 19200 || obs_x[0] !== 0 || obs_y[0] !== 0 || obs_x[19199] !== 159 || obs_y[19199] !== 119) begin
            errors++;
            $display("FAIL clear span: got %0d plots first (%0d,%0d) last (%0d,%0d), want 19200 (0,0) (159,119)",
                     np, obs_x[0], obs_y[0], obs_x[19199], obs_y[19199]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int np;
        test_sweep("rst_idle", 0, 0, 0, 1, np);
        enter(S_CLEAR, 0, 0);
        capture(100);
        checks++;
        if (obs_plot[99] !== 1 || obs_x[99] !== 99 || obs_y[99] !== 0) begin
            errors++;
            $display("FAIL rst pre pixel100: got plot=%0d (%0d,%0d), want 1 (99,0)", obs_plot[99], obs_x[99], obs_y[99]);
        end
        iReset = 1'b1;
        @(negedge clk);
        checks++;
        if (oX !== 0 || oY !== 0 || oColour !== 0 || oPlot !== 0 || oDone !== 0) begin
            errors++;
            $display("FAIL rst mid clear: got x=%0d y=%0d c=%0d plot=%0b done=%0b, want all 0", oX, oY, oColour, oPlot, oDone);
        end
        iReset = 1'b0;
        model_reset();
        enter(S_CLEAR, 0, 0);
        capture(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_plot[k] !== 1 || obs_x[k] !== k || obs_y[k] !== 0 || obs_c[k] !== 0 || obs_done[k] !== 0) begin
                errors++;
                $display("FAIL rst restart pixel %0d: got plot=%0d (%0d,%0d) c=%0d done=%0d, want 1 (%0d,0) c=0 done=0",
                         k, obs_plot[k], obs_x[k], obs_y[k], obs_c[k], obs_done[k], k);
            end
        end
        test_sweep("rst_abort_idle", 0, 0, 0, 4, np);
    endtask

    task automatic test_abort();
        int np, wc;
        enter(S_DRAW, 70, 30);
        capture(2);
        for (int k = 0; k < 2; k++) begin
            wc = drv_col[k];
            checks++;
            if (obs_plot[k] !== 1 || obs_x[k] !== exp_x[k] || obs_y[k] !== exp_y[k] || obs_c[k] !== wc || obs_done[k] !== 0) begin
                errors++;
                $display("FAIL abort draw pixel %0d: got plot=%0d (%0d,%0d) c=%0d done=%0d, want 1 (%0d,%0d) c=%0d done=0",
                         k, obs_plot[k], obs_x[k], obs_y[k], obs_c[k], obs_done[k], exp_x[k], exp_y[k], wc);
            end
        end
        test_sweep("abort_erase", S_ERASE, 90, 60, 3, np);
        checks++;
        if (np !== 4) begin
            errors++;
            $display("FAIL abort erase count: got %0d plots, want 4", np);
        end
    endtask

    task automatic test_back_to_back();
        int np, st, prev, x, y;
        int pool[8] = '{0, 1, 2, 3, 4, 5, 7, 4};
        prev = 0;
        for (int it = 0; it < 30; it++) begin
            do st = pool[$urandom_range(0, 7)]; while (st == prev);
            if ($urandom_range(0, 2) == 0) begin
                x = $urandom_range(154, 159); y = $urandom_range(114, 119);
            end else begin
                x = $urandom_range(0, 159); y = $urandom_range(0, 119);
            end
            test_sweep("random", st, x, y, $urandom_range(0, 2), np);
            prev = st;
        end
    endtask

    initial begin
        test_reset();
        test_draw_basic();
        test_move_clean();
        test_clip();
        test_clear();
        test_reset_mid_clear();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
